bist_misr_checker: RTL and testbench
====================================

BIST_MISR_CHECKER -- requirements
Module: bist_misr_checker

Interface
REQ-001 SHALL have parameter GOLDEN_SIG, default 16'h5555, meaning fault-free signature compared at session end.
REQ-002 SHALL have parameter NUM_PATTERNS, default 2000, meaning patterns compacted per session (legal range 1..2047).
REQ-003 SHALL have parameter SEED, default 16'h0000, meaning MISR value loaded on session start.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a new compaction session.
REQ-007 SHALL have port sample_en  input  1  compact cut_sdo this cycle.
REQ-008 SHALL have port pattern_end  input  1  marks the last unload cycle of one pattern.
REQ-009 SHALL have port cut_sdo  input  4  scan-out bits from the four CUT scan chains.
REQ-010 SHALL have port sig  output  16  current MISR contents.
REQ-011 SHALL have port busy  output  1  high in COMPACT and CHECK.
REQ-012 SHALL have port bistdone  output  1  session complete.
REQ-013 SHALL have port bistpass  output  1  final signature equals GOLDEN_SIG; meaningful only while bistdone=1.
REQ-014 SHALL have port pattern_cnt  output  11  patterns completed in the current session.

Function
REQ-015 SHALL implement FSM states IDLE, COMPACT, CHECK, DONE.
REQ-016 IDLE: start -> COMPACT; MISR <= SEED; pattern_cnt <= 0; bistdone <= 0; bistpass <= 0.
REQ-017 COMPACT: sample_en=1 -> MISR updates per REQ-018; sample_en=0 -> MISR holds.
REQ-018 MISR next state (m = current MISR, d = cut_sdo): n[0]=m15^d3; n[1]=m0; n[2]=m1; n[3]=m2^m15^d2; n[4]=m3^m15^d1; n[5]=m4^m15^d0; n[15:6]=m[14:5].
REQ-019 COMPACT: pattern_end=1 -> pattern_cnt increments; if the incremented value equals NUM_PATTERNS -> CHECK.
REQ-020 sample_en and pattern_end in the same cycle -> that sample is compacted, and the pattern is also counted.
REQ-021 CHECK lasts exactly one cycle: bistpass <= (MISR == GOLDEN_SIG); bistdone <= 1; next state DONE.
REQ-022 bistdone rises exactly one cycle after the rising edge that accepted the final pattern_end.
REQ-023 DONE: bistdone, bistpass, sig and pattern_cnt hold; sample_en and pattern_end are ignored; start -> re-initialise per REQ-016 and go to COMPACT.
REQ-024 start in COMPACT or CHECK -> abort the session, re-initialise per REQ-016, stay in/enter COMPACT; a concurrent sample_en/pattern_end is discarded.
REQ-025 sample_en and pattern_end in IDLE SHALL be ignored.
REQ-026 pattern_cnt SHALL never wrap; it saturates at NUM_PATTERNS.

Reset
REQ-027 rst=1 SHALL asynchronously force state IDLE, MISR=SEED, pattern_cnt=0, bistdone=0, bistpass=0, busy=0.
REQ-028 rst asserted mid-session SHALL discard the session; no partial pass/done is ever reported.
REQ-029 After rst deasserts, the block SHALL wait in IDLE for start.

Configuration
REQ-030 Macro BIST_DIAG_EN, when defined, SHALL enable diagnostic early-fail behaviour: at each pattern_end in COMPACT, the post-update MISR is compared with GOLDEN_SIG. If the number of patterns remaining is 0 and there is a mismatch, CHECK is skipped: bistdone=1 and bistpass=0 are set on the same edge, and the FSM goes to DONE.
REQ-031 When BIST_DIAG_EN is defined, sig and pattern_cnt SHALL be live outputs; when it is undefined, sig and pattern_cnt SHALL be driven constant 0, and only CHECK (REQ-021) decides pass.

Verification
REQ-032 rst pulse, start, SEED=0, one sample_en with cut_sdo=4'b1000 -> sig=16'h0001; then sample_en with cut_sdo=0 -> sig=16'h0002.
REQ-033 SEED=16'h8000, start, sample_en with cut_sdo=0 -> sig=16'h0039.
REQ-034 NUM_PATTERNS=3, GOLDEN_SIG set to the precomputed value, 3 patterns (pattern_end on the last sample of each) -> bistdone=1 one cycle after the 3rd pattern_end, bistpass=1, pattern_cnt=3.
REQ-035 Same stimulus as REQ-034 with one cut_sdo bit flipped -> bistdone=1, bistpass=0.
REQ-036 rst asserted asynchronously mid-session after 2 patterns -> bistdone=0, bistpass=0 and pattern_cnt=0 immediately, without waiting for a clock; the FSM stays in IDLE until start.
REQ-037 start pulse while in DONE -> bistdone=0 next cycle, sig=SEED, busy=1; a new session completes normally.

Source files
------------

// File: rtl/bist_misr_checker.sv
// BIST signature checker: compacts four scan-out streams into a 16-bit MISR and
// compares against GOLDEN_SIG after NUM_PATTERNS patterns. Optional macro: BIST_DIAG_EN.
module bist_misr_checker #(
  parameter logic [15:0] GOLDEN_SIG   = 16'h5555,
  parameter int unsigned NUM_PATTERNS = 2000,
  parameter logic [15:0] SEED         = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sample_en,
  input  logic        pattern_end,
  input  logic [3:0]  cut_sdo,
  output logic [15:0] sig,
  output logic        busy,
  output logic        bistdone,
  output logic        bistpass,
  output logic [10:0] pattern_cnt
);

  typedef enum logic [1:0] {IDLE, COMPACT, CHECK, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] misr, misr_n, misr_step;
  logic [10:0] cnt, cnt_n, cnt_inc;
  logic        done, done_n, pass, pass_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      misr  <= SEED;
      cnt   <= '0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      state <= state_n;
      misr  <= misr_n;
      cnt   <= cnt_n;
      done  <= done_n;
      pass  <= pass_n;
    end
  end

  always_comb begin
    misr_step = {misr[14:5],
                 misr[4] ^ misr[15] ^ cut_sdo[0],
                 misr[3] ^ misr[15] ^ cut_sdo[1],
                 misr[2] ^ misr[15] ^ cut_sdo[2],
                 misr[1],
                 misr[0],
                 misr[15] ^ cut_sdo[3]};
    cnt_inc = cnt + 11'd1;
  end

  always_comb begin
    state_n = state;
    misr_n  = misr;
    cnt_n   = cnt;
    done_n  = done;
    pass_n  = pass;
    // start wins in every state, so any concurrent sample/pattern_end is dropped
    if (start) begin
      state_n = COMPACT;
      misr_n  = SEED;
      cnt_n   = '0;
      done_n  = 1'b0;
      pass_n  = 1'b0;
    end else begin
      case (state)
        COMPACT: begin
          if (sample_en) misr_n = misr_step;
          if (pattern_end) begin
            cnt_n = cnt_inc;
            if (cnt_inc == 11'(NUM_PATTERNS)) begin
              state_n = CHECK;
`ifdef BIST_DIAG_EN
              if (misr_n != GOLDEN_SIG) begin
                done_n  = 1'b1;
                pass_n  = 1'b0;
                state_n = DONE;
              end
`endif
            end
          end
        end
        CHECK: begin
          pass_n  = (misr == GOLDEN_SIG);
          done_n  = 1'b1;
          state_n = DONE;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == COMPACT) || (state == CHECK);
  assign bistdone = done;
  assign bistpass = pass;

`ifdef BIST_DIAG_EN
  assign sig         = misr;
  assign pattern_cnt = cnt;
`else
  assign sig         = '0;
  assign pattern_cnt = '0;
`endif

endmodule

// File: tb/tb_bist_misr_checker.sv
// Scoreboard bench for bist_misr_checker: a polynomial-division MISR model predicts
// each session's verdict; a negedge monitor checks it when bistdone rises.
module tb_bist_misr_checker;

  localparam int NP  = 3;
  localparam int SPP = 4;
  localparam logic [15:0] SEED_V = 16'h0000;
`ifdef BIST_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  // MISR as multiply-by-x modulo x^16+x^5+x^4+x^3+1, plus injected data bits
  function automatic logic [15:0] misr_model(input logic [15:0] m, input logic [3:0] d);
    logic [15:0] r;
    logic [15:0] inj;
    r = m << 1;
    if (m[15]) r = r ^ 16'h0039;
    inj = '0;
    inj[0] = d[3];
    inj[3] = d[2];
    inj[4] = d[1];
    inj[5] = d[0];
    return r ^ inj;
  endfunction

  function automatic logic [3:0] gold_data(input int i);
    return 4'((i * 7 + 3) ^ (i >> 1));
  endfunction

  function automatic logic [15:0] calc_gold();
    logic [15:0] m;
    m = SEED_V;
    for (int i = 0; i < NP * SPP; i++) m = misr_model(m, gold_data(i));
    return m;
  endfunction

  localparam logic [15:0] GOLD = calc_gold();

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sample_en = 1'b0;
  logic        pattern_end = 1'b0;
  logic [3:0]  cut_sdo = '0;
  logic [15:0] sig;
  logic        busy, bistdone, bistpass;
  logic [10:0] pattern_cnt;

  bist_misr_checker #(
    .GOLDEN_SIG(GOLD),
    .NUM_PATTERNS(NP),
    .SEED(SEED_V)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .sample_en(sample_en),
    .pattern_end(pattern_end),
    .cut_sdo(cut_sdo),
    .sig(sig),
    .busy(busy),
    .bistdone(bistdone),
    .bistpass(bistpass),
    .pattern_cnt(pattern_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pass;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: verdict checked on every bistdone rising
  always @(negedge clk) begin
    if (bistdone && !prev_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got bistdone=1 expected no completion (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("bistpass", {31'd0, bistpass}, {31'd0, e.pass});
        chk("pattern_cnt_at_done", {21'd0, pattern_cnt}, DIAG ? NP : 0);
      end
    end
    prev_done = bistdone;
  end

  // Drives start plus npat patterns; a full session pushes its predicted verdict
  task automatic drive_session(input int flip, input bit use_rand, input int npat,
                               output logic [15:0] m);
    logic [3:0] d;
    int idx;
    @(negedge clk);
    start = 1'b1;
    sample_en = 1'($urandom);
    pattern_end = 1'($urandom);
    cut_sdo = 4'($urandom);
    @(negedge clk);
    start = 1'b0;
    sample_en = 1'b0;
    pattern_end = 1'b0;
    m = SEED_V;
    chk("busy_after_start", {31'd0, busy}, 1);
    chk("done_after_start", {31'd0, bistdone}, 0);
    chk("sig_after_start", {16'd0, sig}, {16'd0, SEED_V});
    for (int p = 0; p < npat; p++) begin
      for (int s = 0; s < SPP; s++) begin
        repeat ($urandom_range(0, 2)) begin
          sample_en = 1'b0;
          pattern_end = 1'b0;
          cut_sdo = 4'($urandom);
          @(negedge clk);
        end
        idx = p * SPP + s;
        d = use_rand ? 4'($urandom) : gold_data(idx);
        if (idx == flip) d = d ^ (4'd1 << $urandom_range(0, 3));
        m = misr_model(m, d);
        sample_en = 1'b1;
        cut_sdo = d;
        pattern_end = (s == SPP - 1);
        if (npat == NP && p == NP - 1 && s == SPP - 1) begin
          exp_t e;
          e.pass = (m == GOLD);
          e.cyc = cyc + ((DIAG && m != GOLD) ? 1 : 2);
          sb.push_back(e);
        end
        @(negedge clk);
        chk("sig_live", {16'd0, sig}, DIAG ? {16'd0, m} : 0);
      end
      chk("pattern_cnt_live", {21'd0, pattern_cnt}, DIAG ? p + 1 : 0);
    end
    sample_en = 1'b0;
    pattern_end = 1'b0;
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no bistdone within 20 cycles expected completion");
      sb.delete();
    end
  endtask

  initial begin
    logic [15:0] m;
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, bistdone}, 0);
    chk("reset_pass", {31'd0, bistpass}, 0);
    chk("reset_cnt", {21'd0, pattern_cnt}, 0);
    chk("reset_sig", {16'd0, sig}, {16'd0, SEED_V});
    @(negedge clk);
    rst = 1'b0;

    // Inputs in IDLE are ignored
    repeat (3) begin
      sample_en = 1'b1;
      pattern_end = 1'b1;
      cut_sdo = 4'($urandom);
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_done", {31'd0, bistdone}, 0);
    end
    sample_en = 1'b0;
    pattern_end = 1'b0;

    drive_session(-1, 1'b0, NP, m);
    wait_sb();

    // DONE holds and ignores sample/pattern activity
    repeat (3) begin
      sample_en = 1'b1;
      pattern_end = 1'b1;
      cut_sdo = 4'($urandom);
      @(negedge clk);
      chk("done_hold_done", {31'd0, bistdone}, 1);
      chk("done_hold_pass", {31'd0, bistpass}, 1);
      chk("done_hold_busy", {31'd0, busy}, 0);
      chk("done_hold_sig", {16'd0, sig}, DIAG ? {16'd0, GOLD} : 0);
    end
    sample_en = 1'b0;
    pattern_end = 1'b0;

    for (int k = 0; k < 3; k++) begin
      drive_session($urandom_range(0, NP * SPP - 1), 1'b0, NP, m);
      wait_sb();
    end

    for (int k = 0; k < 3; k++) begin
      drive_session(-1, 1'b1, NP, m);
      wait_sb();
    end

    // Abort mid-session, then a clean session must still pass
    drive_session(-1, 1'b1, 2, m);
    drive_session(-1, 1'b0, NP, m);
    wait_sb();

    // Async reset while DONE/pass is showing
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_done", {31'd0, bistdone}, 0);
    chk("async_rst_pass", {31'd0, bistpass}, 0);
    chk("async_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-session after 2 patterns
    drive_session(-1, 1'b0, 2, m);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_done", {31'd0, bistdone}, 0);
    chk("mid_rst_cnt", {21'd0, pattern_cnt}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      sample_en = 1'b1;
      pattern_end = 1'b1;
      @(negedge clk);
      chk("post_rst_idle_busy", {31'd0, busy}, 0);
      chk("post_rst_idle_done", {31'd0, bistdone}, 0);
    end
    sample_en = 1'b0;
    pattern_end = 1'b0;

    drive_session(-1, 1'b0, NP, m);
    wait_sb();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
